// File: rtl/wb_uart_arbiter.sv
// wb_uart_arbiter: two-master Wishbone arbiter in front of the wb_uart slave.
// Master 0 is the CPU and master 1 is the debug/loader port. Each grant uses
// round-robin order. A grant is registered and is held for one whole slave
// transaction. It is released on the slave ack, on an owner abort (cyc drop)
// or on a watchdog timeout.
// Optional feature: define WB_ARB_TIMEOUT_EN to enable the bus-error watchdog.
// When that macro is not defined, m0_err_o and m1_err_o are tied to 0.
module wb_uart_arbiter #(
  parameter int TIMEOUT_W      = 20,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic [15:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic [15:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o,
  output logic        busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] grant, grant_nxt;
  logic       last, last_nxt;   // 1: master 1 was served last, so master 0 wins a tie
  logic       req0, req1;
  logic       busy;
  logic       own_cyc;
  logic       tmo;              // watchdog expiry in the current BUSY cycle

  // A timeout window that cannot be represented by the counter is a build error.
  if ((TIMEOUT_CYCLES < 1) ||
      (longint'(TIMEOUT_CYCLES) >= (longint'(1) << TIMEOUT_W))) begin : g_bad_timeout
    $error("wb_uart_arbiter: TIMEOUT_CYCLES must lie in 1 .. 2**TIMEOUT_W-1");
  end

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign busy    = (state == BUSY);
  assign own_cyc = grant[1] ? m1_cyc_i : m0_cyc_i;

`ifdef WB_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;

  // Count BUSY cycles that have no ack. The count is held at zero while IDLE, so each grant starts from 0.
  always_ff @(posedge clk) begin
    if (rst || !busy) begin
      tmo_cnt <= '0;
    end else if (!s_ack_i) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // An ack in the same cycle takes priority over the timeout.
  assign tmo = busy & ~s_ack_i & (tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  // Arbiter control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 2'b00;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  // Next state: round-robin grant from IDLE, release on ack, abort or timeout
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          grant_nxt = last ? 2'b01 : 2'b10;
          state_nxt = BUSY;
        end else if (req0) begin
          grant_nxt = 2'b01;
          state_nxt = BUSY;
        end else if (req1) begin
          grant_nxt = 2'b10;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (s_ack_i || !own_cyc || tmo) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
          last_nxt  = grant[1];
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // Slave-side mux: the owner's signals pass through only while BUSY
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    if (busy) begin
      if (grant[1]) begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_stb_o = m1_stb_i & ~tmo;
        s_cyc_o = m1_cyc_i & ~tmo;
      end else begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_stb_o = m0_stb_i & ~tmo;
        s_cyc_o = m0_cyc_i & ~tmo;
      end
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & grant[0] & busy;
  assign m1_ack_o = s_ack_i & grant[1] & busy;
  assign m0_err_o = tmo & grant[0];
  assign m1_err_o = tmo & grant[1];
  assign grant_o  = grant;
  assign busy_o   = busy;

endmodule

// File: tb/tb_wb_uart_arbiter.sv
// Testbench for wb_uart_arbiter. Directed scenarios are followed by randomized
// traffic. Every cycle is compared against a behavioural ownership model.
module tb_wb_uart_arbiter;

  localparam int TMO_W   = 20;
  localparam int TMO_CYC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic        m_we  [2];
  logic [3:0]  m_sel [2];
  logic        m_stb [2];
  logic        m_cyc [2];
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic [15:0] s_adr;
  logic [31:0] s_wdat;
  logic        s_we, s_stb, s_cyc;
  logic [3:0]  s_sel;
  logic        s_ack;
  logic [31:0] s_rdat;
  logic [1:0]  grant;
  logic        busy;

  always #5 clk = ~clk;

  wb_uart_arbiter #(
    .TIMEOUT_W      (TMO_W),
    .TIMEOUT_CYCLES (TMO_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_adr_i (m_adr[0]),
    .m0_dat_i (m_dat[0]),
    .m0_we_i  (m_we[0]),
    .m0_sel_i (m_sel[0]),
    .m0_stb_i (m_stb[0]),
    .m0_cyc_i (m_cyc[0]),
    .m0_ack_o (m0_ack),
    .m0_err_o (m0_err),
    .m0_dat_o (m0_rdat),
    .m1_adr_i (m_adr[1]),
    .m1_dat_i (m_dat[1]),
    .m1_we_i  (m_we[1]),
    .m1_sel_i (m_sel[1]),
    .m1_stb_i (m_stb[1]),
    .m1_cyc_i (m_cyc[1]),
    .m1_ack_o (m1_ack),
    .m1_err_o (m1_err),
    .m1_dat_o (m1_rdat),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_wdat),
    .s_we_o   (s_we),
    .s_sel_o  (s_sel),
    .s_stb_o  (s_stb),
    .s_cyc_o  (s_cyc),
    .s_ack_i  (s_ack),
    .s_dat_i  (s_rdat),
    .grant_o  (grant),
    .busy_o   (busy)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: owner of the bus (-1 when free), last master served, cycles spent owned
  int owner;
  int last_won;
  int own_cycles;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                       input logic [15:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    m_cyc[i] = cyc;
    m_stb[i] = stb;
    m_we[i]  = we;
    m_adr[i] = adr;
    m_dat[i] = dat;
    m_sel[i] = sel;
  endtask

  // Called just after a falling edge: check all outputs, advance the model, go to the next falling edge
  task automatic tick();
    logic        to;
    logic [1:0]  eg;
    logic [15:0] ea;
    logic [31:0] ed;
    logic        ewe, ecyc, estb;
    logic [3:0]  esel;
    logic        eack [2];
    logic        eerr [2];
    logic        r0, r1;
    #1;
    to = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    if (owner >= 0 && !s_ack && own_cycles == TMO_CYC - 1) to = 1'b1;
`endif
    eg = 2'b00; ea = '0; ed = '0; ewe = 1'b0; ecyc = 1'b0; estb = 1'b0; esel = '0;
    eack[0] = 1'b0; eack[1] = 1'b0; eerr[0] = 1'b0; eerr[1] = 1'b0;
    if (owner >= 0) begin
      eg   = (owner == 1) ? 2'b10 : 2'b01;
      ea   = m_adr[owner];
      ed   = m_dat[owner];
      ewe  = m_we[owner];
      esel = m_sel[owner];
      ecyc = m_cyc[owner] & ~to;
      estb = m_stb[owner] & ~to;
      eack[owner] = s_ack;
      eerr[owner] = to;
    end
    check_eq("grant",  32'(grant),   32'(eg));
    check_eq("busy",   32'(busy),    32'(owner >= 0));
    check_eq("s_adr",  32'(s_adr),   32'(ea));
    check_eq("s_dat",  s_wdat,       ed);
    check_eq("s_we",   32'(s_we),    32'(ewe));
    check_eq("s_sel",  32'(s_sel),   32'(esel));
    check_eq("s_cyc",  32'(s_cyc),   32'(ecyc));
    check_eq("s_stb",  32'(s_stb),   32'(estb));
    check_eq("m0_ack", 32'(m0_ack),  32'(eack[0]));
    check_eq("m1_ack", 32'(m1_ack),  32'(eack[1]));
    check_eq("m0_err", 32'(m0_err),  32'(eerr[0]));
    check_eq("m1_err", 32'(m1_err),  32'(eerr[1]));
    check_eq("m0_dat", m0_rdat,      s_rdat);
    check_eq("m1_dat", m1_rdat,      s_rdat);
    r0 = m_cyc[0] & m_stb[0];
    r1 = m_cyc[1] & m_stb[1];
    if (rst) begin
      owner = -1; last_won = 1; own_cycles = 0;
    end else if (owner < 0) begin
      if (r0 && r1)  owner = 1 - last_won;
      else if (r0)   owner = 0;
      else if (r1)   owner = 1;
      own_cycles = 0;
    end else if (s_ack || !m_cyc[owner] || to) begin
      last_won = owner; owner = -1; own_cycles = 0;
    end else begin
      own_cycles++;
    end
    @(negedge clk);
  endtask

  task automatic clear_masters();
    set_m(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
  endtask

  logic [1:0] order_q[$];
  logic [1:0] prev_g;

  initial begin
    rst = 1'b1; s_ack = 1'b0; s_rdat = '0;
    clear_masters();
    repeat (3) @(posedge clk);
    @(negedge clk);
    owner = -1; last_won = 1; own_cycles = 0;
    tick();                       // reset state while rst is still asserted
    rst = 1'b0;

    // m0 writes 0x41 alone
    set_m(0, 1'b1, 1'b1, 1'b1, 16'h0004, 32'h41, 4'h1);
    tick(); tick();
    s_ack = 1'b1; tick(); s_ack = 1'b0;
    clear_masters(); tick();

    // Simultaneous requests after reset: served m0, m1, m0, m1
    rst = 1'b1; tick(); rst = 1'b0;
    set_m(0, 1'b1, 1'b1, 1'b1, 16'h0008, 32'h11, 4'hF);
    set_m(1, 1'b1, 1'b1, 1'b0, 16'h000C, 32'h22, 4'hF);
    s_ack = 1'b1;
    prev_g = 2'b00;
    for (int k = 0; k < 9; k++) begin
      if (grant != 2'b00 && prev_g == 2'b00) order_q.push_back(grant);
      prev_g = grant;
      tick();
    end
    check_eq("rr_count", 32'(order_q.size() >= 4), 32'd1);
    check_eq("rr_0", 32'((order_q.size() > 0) ? order_q[0] : 2'b00), 32'd1);
    check_eq("rr_1", 32'((order_q.size() > 1) ? order_q[1] : 2'b00), 32'd2);
    check_eq("rr_2", 32'((order_q.size() > 2) ? order_q[2] : 2'b00), 32'd1);
    check_eq("rr_3", 32'((order_q.size() > 3) ? order_q[3] : 2'b00), 32'd2);
    s_ack = 1'b0; clear_masters(); tick();

    // m1 read waits while m0 owns the bus, then receives 0x5A
    set_m(0, 1'b1, 1'b1, 1'b1, 16'h0010, 32'hAA, 4'hF);
    tick(); tick();
    set_m(1, 1'b1, 1'b1, 1'b0, 16'h0020, 32'h0, 4'hF);
    tick(); tick();
    s_ack = 1'b1; tick(); s_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    tick(); tick();
    s_rdat = 32'h5A; s_ack = 1'b1; tick(); s_ack = 1'b0;
    clear_masters(); tick();

    // m0 aborts mid-transfer, pending m1 is served next
    set_m(0, 1'b1, 1'b1, 1'b1, 16'h0030, 32'h33, 4'h3);
    tick();
    set_m(1, 1'b1, 1'b1, 1'b1, 16'h0040, 32'h44, 4'hC);
    tick();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    tick(); tick(); tick();
    s_ack = 1'b1; tick(); s_ack = 1'b0;
    clear_masters(); tick();

    // Reset in the middle of a transfer
    set_m(0, 1'b1, 1'b1, 1'b0, 16'h0050, 32'h0, 4'hF);
    tick(); tick();
    rst = 1'b1; s_ack = 1'b1; tick(); rst = 1'b0; s_ack = 1'b0;
    clear_masters(); tick(); tick();

    // Slave that never acks: watchdog when enabled, otherwise the grant is held indefinitely
    set_m(0, 1'b1, 1'b1, 1'b0, 16'h0060, 32'h0, 4'hF);
    repeat (22) tick();
    clear_masters(); tick(); tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!m_cyc[i]) m_cyc[i] = ($urandom_range(0, 2) == 0);
        else if ($urandom_range(0, 9) == 0) m_cyc[i] = 1'b0;
        m_stb[i] = m_cyc[i] & ($urandom_range(0, 3) != 0);
        m_we[i]  = 1'($urandom_range(0, 1));
        m_adr[i] = 16'($urandom);
        m_dat[i] = $urandom;
        m_sel[i] = 4'($urandom);
      end
      s_ack  = ($urandom_range(0, 2) == 0);
      s_rdat = $urandom;
      rst    = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
